// File: rtl/control_unit_ver1.sv
// RV32I main decoder: registered control word from op/func3/func7, one cycle latency.
// Define CU_RV32M_EN to decode the M-extension (R-type, func7 0000001) onto alu_op 17-24.
module control_unit_ver1 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [6:0] func7,
   input  logic [2:0] func3,
   output logic       w_reg,
   output logic [4:0] alu_op,
   output logic [2:0] r_dm,
   output logic [1:0] w_dm,
   output logic [2:0] sign_ext,
   output logic       branch,
   output logic       alu_src,
   output logic [1:0] reg_dest,
   output logic       pc_sel,
   output logic       b_or_j
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic       w_w_reg;
   logic [4:0] w_alu_op;
   logic [2:0] w_r_dm;
   logic [1:0] w_w_dm;
   logic [2:0] w_sign_ext;
   logic       w_branch;
   logic       w_alu_src;
   logic [1:0] w_reg_dest;
   logic       w_pc_sel;
   logic       w_b_or_j;

   always_comb begin
      w_w_reg    = 1'b0;
      w_alu_op   = 5'd0;
      w_r_dm     = 3'd0;
      w_w_dm     = 2'd0;
      w_sign_ext = 3'd0;
      w_branch   = 1'b0;
      w_alu_src  = 1'b0;
      w_reg_dest = 2'd0;
      w_pc_sel   = 1'b0;
      w_b_or_j   = 1'b0;
      // Illegal sub-encodings simply skip their assignments and fall back to the all-zero NOP.
      case (op)
         OP_R: begin
            if (func7 == 7'b0000000) begin
               w_w_reg = 1'b1;
               case (func3)
                  3'b000:  w_alu_op = 5'd0;
                  3'b001:  w_alu_op = 5'd2;
                  3'b010:  w_alu_op = 5'd3;
                  3'b011:  w_alu_op = 5'd4;
                  3'b100:  w_alu_op = 5'd5;
                  3'b101:  w_alu_op = 5'd6;
                  3'b110:  w_alu_op = 5'd8;
                  default: w_alu_op = 5'd9;
               endcase
            end else if (func7 == 7'b0100000) begin
               if (func3 == 3'b000) begin
                  w_w_reg  = 1'b1;
                  w_alu_op = 5'd1;
               end else if (func3 == 3'b101) begin
                  w_w_reg  = 1'b1;
                  w_alu_op = 5'd7;
               end
            end
`ifdef CU_RV32M_EN
            else if (func7 == 7'b0000001) begin
               w_w_reg  = 1'b1;
               w_alu_op = 5'd17 + {2'b00, func3};
            end
`else
            else begin
               w_w_reg = 1'b0;
            end
`endif
         end
         OP_I: begin
            w_w_reg    = 1'b1;
            w_alu_src  = 1'b1;
            w_sign_ext = 3'd1;
            case (func3)
               3'b000:  w_alu_op = 5'd0;
               3'b001:  w_alu_op = 5'd2;
               3'b010:  w_alu_op = 5'd3;
               3'b011:  w_alu_op = 5'd4;
               3'b100:  w_alu_op = 5'd5;
               3'b101:  w_alu_op = func7[5] ? 5'd7 : 5'd6;
               3'b110:  w_alu_op = 5'd8;
               default: w_alu_op = 5'd9;
            endcase
         end
         OP_LOAD: begin
            if (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
               w_w_reg    = 1'b1;
               w_alu_src  = 1'b1;
               w_sign_ext = 3'd1;
               w_reg_dest = 2'd1;
               case (func3)
                  3'b000:  w_r_dm = 3'd1;
                  3'b001:  w_r_dm = 3'd2;
                  3'b010:  w_r_dm = 3'd3;
                  3'b100:  w_r_dm = 3'd4;
                  default: w_r_dm = 3'd5;
               endcase
            end
         end
         OP_STORE: begin
            if (func3 inside {3'b000, 3'b001, 3'b010}) begin
               w_alu_src  = 1'b1;
               w_sign_ext = 3'd2;
               w_w_dm     = func3[1:0] + 2'd1;
            end
         end
         OP_BR: begin
            if (func3 != 3'b010 && func3 != 3'b011) begin
               w_branch   = 1'b1;
               w_sign_ext = 3'd3;
               case (func3)
                  3'b000:  w_alu_op = 5'd10;
                  3'b001:  w_alu_op = 5'd11;
                  3'b100:  w_alu_op = 5'd12;
                  3'b101:  w_alu_op = 5'd13;
                  3'b110:  w_alu_op = 5'd14;
                  default: w_alu_op = 5'd15;
               endcase
            end
         end
         OP_JAL, OP_JALR: begin
            if (op == OP_JAL || func3 == 3'b000) begin
               w_w_reg    = 1'b1;
               w_branch   = 1'b1;
               w_b_or_j   = 1'b1;
               w_alu_src  = 1'b1;
               w_reg_dest = 2'd2;
               w_pc_sel   = (op == OP_JALR);
               w_sign_ext = (op == OP_JALR) ? 3'd1 : 3'd5;
            end
         end
         OP_LUI: begin
            w_w_reg    = 1'b1;
            w_alu_src  = 1'b1;
            w_alu_op   = 5'd16;
            w_sign_ext = 3'd4;
            w_reg_dest = 2'd3;
         end
         default: w_w_reg = 1'b0;
      endcase
   end

   // Decode -> registered control word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_reg    <= 1'b0;
         alu_op   <= 5'd0;
         r_dm     <= 3'd0;
         w_dm     <= 2'd0;
         sign_ext <= 3'd0;
         branch   <= 1'b0;
         alu_src  <= 1'b0;
         reg_dest <= 2'd0;
         pc_sel   <= 1'b0;
         b_or_j   <= 1'b0;
      end else begin
         w_reg    <= w_w_reg;
         alu_op   <= w_alu_op;
         r_dm     <= w_r_dm;
         w_dm     <= w_w_dm;
         sign_ext <= w_sign_ext;
         branch   <= w_branch;
         alu_src  <= w_alu_src;
         reg_dest <= w_reg_dest;
         pc_sel   <= w_pc_sel;
         b_or_j   <= w_b_or_j;
      end
   end

endmodule

// File: tb/tb_control_unit_ver1.sv
// Directed bench for control_unit_ver1; expected control words are hand-computed.
module tb_control_unit_ver1;

   logic       clk;
   logic       rst_n;
   logic [6:0] op;
   logic [6:0] func7;
   logic [2:0] func3;
   logic       w_reg;
   logic [4:0] alu_op;
   logic [2:0] r_dm;
   logic [1:0] w_dm;
   logic [2:0] sign_ext;
   logic       branch;
   logic       alu_src;
   logic [1:0] reg_dest;
   logic       pc_sel;
   logic       b_or_j;

   int total = 0;
   int bad   = 0;

   control_unit_ver1 dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func7(func7), .func3(func3),
      .w_reg(w_reg), .alu_op(alu_op), .r_dm(r_dm), .w_dm(w_dm),
      .sign_ext(sign_ext), .branch(branch), .alu_src(alu_src),
      .reg_dest(reg_dest), .pc_sel(pc_sel), .b_or_j(b_or_j)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Full control word: w_reg alu_op r_dm w_dm sign_ext branch alu_src reg_dest pc_sel b_or_j
   task automatic chk_all(input string tag, input int e_wr, input int e_aop, input int e_rdm,
                          input int e_wdm, input int e_sx, input int e_br, input int e_as,
                          input int e_rd, input int e_ps, input int e_bj);
      chk({tag, ".w_reg"},    8'(w_reg),    8'(e_wr));
      chk({tag, ".alu_op"},   8'(alu_op),   8'(e_aop));
      chk({tag, ".r_dm"},     8'(r_dm),     8'(e_rdm));
      chk({tag, ".w_dm"},     8'(w_dm),     8'(e_wdm));
      chk({tag, ".sign_ext"}, 8'(sign_ext), 8'(e_sx));
      chk({tag, ".branch"},   8'(branch),   8'(e_br));
      chk({tag, ".alu_src"},  8'(alu_src),  8'(e_as));
      chk({tag, ".reg_dest"}, 8'(reg_dest), 8'(e_rd));
      chk({tag, ".pc_sel"},   8'(pc_sel),   8'(e_ps));
      chk({tag, ".b_or_j"},   8'(b_or_j),   8'(e_bj));
   endtask

   task automatic apply(input logic [6:0] o, input logic [6:0] f7, input logic [2:0] f3);
      op = o; func7 = f7; func3 = f3;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      op = 7'b0110011; func7 = 7'd0; func3 = 3'd0;
      #2;
      chk_all("reset", 0,0,0,0,0,0,0,0,0,0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply(7'b0110011, 7'b0000000, 3'b000);
      chk_all("add", 1,0,0,0,0,0,0,0,0,0);
      apply(7'b0110011, 7'b0100000, 3'b000);
      chk_all("sub", 1,1,0,0,0,0,0,0,0,0);
      apply(7'b0110011, 7'b0100000, 3'b101);
      chk_all("sra", 1,7,0,0,0,0,0,0,0,0);
      apply(7'b0010011, 7'b0100000, 3'b001);
      chk_all("slli", 1,2,0,0,1,0,1,0,0,0);
      apply(7'b0010011, 7'b0100000, 3'b101);
      chk_all("srai", 1,7,0,0,1,0,1,0,0,0);
      apply(7'b0010011, 7'b0000000, 3'b110);
      chk_all("ori", 1,8,0,0,1,0,1,0,0,0);
      apply(7'b0110011, 7'b0100000, 3'b111);
      chk_all("r_bad_f3", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b0110011, 7'b1000000, 3'b000);
      chk_all("r_bad_f7", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b0000011, 7'b0000000, 3'b010);
      chk_all("lw", 1,0,3,0,1,0,1,1,0,0);
      apply(7'b0000011, 7'b0000000, 3'b101);
      chk_all("lhu", 1,0,5,0,1,0,1,1,0,0);
      apply(7'b0000011, 7'b0000000, 3'b011);
      chk_all("load_bad", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b0100011, 7'b0000000, 3'b001);
      chk_all("sh", 0,0,0,2,2,0,1,0,0,0);
      apply(7'b0100011, 7'b0000000, 3'b100);
      chk_all("store_bad", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b1101111, 7'b0000000, 3'b011);
      chk_all("jal", 1,0,0,0,5,1,1,2,0,1);
      apply(7'b1100111, 7'b0000000, 3'b000);
      chk_all("jalr", 1,0,0,0,1,1,1,2,1,1);
      apply(7'b1100111, 7'b0000000, 3'b001);
      chk_all("jalr_bad", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b1100011, 7'b0000000, 3'b001);
      chk_all("bne", 0,11,0,0,3,1,0,0,0,0);
      apply(7'b1100011, 7'b0000000, 3'b111);
      chk_all("bgeu", 0,15,0,0,3,1,0,0,0,0);
      apply(7'b1100011, 7'b0000000, 3'b010);
      chk_all("br_bad", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b0110111, 7'b1010101, 3'b101);
      chk_all("lui", 1,16,0,0,4,0,1,3,0,0);
      apply(7'b1111111, 7'b0000000, 3'b000);
      chk_all("undef", 0,0,0,0,0,0,0,0,0,0);
      apply(7'b0010111, 7'b0000000, 3'b000);
      chk_all("auipc", 0,0,0,0,0,0,0,0,0,0);

      // Asynchronous reset in the middle of a cycle
      apply(7'b0110011, 7'b0000000, 3'b000);
      chk_all("add2", 1,0,0,0,0,0,0,0,0,0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0,0,0,0,0,0,0,0,0,0);
      op = 7'b1100011; func7 = 7'd0; func3 = 3'b001;
      @(posedge clk); #1;
      chk_all("rst_hold", 0,0,0,0,0,0,0,0,0,0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all("rst_release", 0,0,0,0,0,0,0,0,0,0);
      @(posedge clk); #1;
      chk_all("bne_after_rst", 0,11,0,0,3,1,0,0,0,0);

      apply(7'b0110011, 7'b0000001, 3'b100);
`ifdef CU_RV32M_EN
      chk_all("div", 1,21,0,0,0,0,0,0,0,0);
`else
      chk_all("div_off", 0,0,0,0,0,0,0,0,0,0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
